// File: rtl/tmiv_cnt_mc.sv
// Multi-channel event interval counter: dual-phase sampling, per-channel half-period
// accumulators, round-robin merge into a show-ahead FIFO. Option: TMIV_CNT_MC_GLITCH_REJECT_EN.
module tmiv_cnt_mc #(
  parameter int NCH     = 4,
  parameter int CNT_W   = 8,
  parameter int FIFO_AW = 3,
  parameter int SYNC_S  = 2
) (
  input  logic             hsclkp,
  input  logic             hsclkn,
  input  logic             _rst,
  input  logic [NCH-1:0]   evs,
  input  logic             en,
  output logic [CNT_W+4:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       drop_cnt,
  output logic             err
);

  localparam int RW    = CNT_W + 5;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef logic [RW-1:0] rec_t;

  // Returns {clamped, value}; the sum is clamped to the all-ones count.
  function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? {1'b1, CMAX} : s;
  endfunction

  function automatic logic [7:0] sat_drop(input logic [7:0] cnt, input logic [3:0] inc);
    logic [8:0] s;
    s = {1'b0, cnt} + 9'(inc);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [NCH-1:0][SYNC_S-1:0] syn_p_q, syn_p_d, syn_n_q, syn_n_d;
  logic [NCH-1:0]             sa_q, sa_d, prev_q, prev_d, sb;

  logic [NCH-1:0][CNT_W-1:0]  acc_q, acc_d;
  logic [NCH-1:0]             armed_q, armed_d, satf_q, satf_d;
  logic [NCH-1:0]             vld_p0_q, vld_p0_d;
  rec_t [NCH-1:0]             rec_p0_q, rec_p0_d;
  logic                       rej_any;

  logic [NCH-1:0]             pvld_p1_q, pvld_p1_d;
  rec_t [NCH-1:0]             prec_p1_q, prec_p1_d;
  logic [NCH-1:0]             gnt;
  logic [PW-1:0]              ptr_q, ptr_d;

  logic                       wr_en, rd_en, full;
  rec_t                       wr_data;
  rec_t                       mem_q [DEPTH];
  logic [FIFO_AW:0]           wp_q, wp_d, rp_q, rp_d, used;
  logic [3:0]                 ndrop;
  logic [7:0]                 drop_cnt_q, drop_cnt_d;
  logic                       err_q, err_d;

  // Sampler: two synchroniser chains, one per clock phase; the later sample (s_b)
  // is the posedge chain, the earlier (s_a) is the negedge chain retimed to hsclkp.
  always_comb begin
    syn_p_d = syn_p_q;
    syn_n_d = syn_n_q;
    sa_d    = sa_q;
    prev_d  = prev_q;
    sb      = '0;
    for (int c = 0; c < NCH; c++) begin
      syn_p_d[c][0] = evs[c];
      syn_n_d[c][0] = evs[c];
      for (int s = 1; s < SYNC_S; s++) begin
        syn_p_d[c][s] = syn_p_q[c][s-1];
        syn_n_d[c][s] = syn_n_q[c][s-1];
      end
      sb[c]     = syn_p_q[c][SYNC_S-1];
      sa_d[c]   = syn_n_q[c][SYNC_S-1];
      prev_d[c] = sb[c];
    end
  end

  always_ff @(posedge hsclkn or negedge _rst) begin
    if (!_rst) syn_n_q <= '0;
    else       syn_n_q <= syn_n_d;
  end

  // Stage p0: edge classification, interval accumulation, record formation.
  always_comb begin
    logic [2:0]     pat;
    logic           ev, ph2, gl, rej;
    logic [CNT_W:0] sum;
    acc_d    = acc_q;
    armed_d  = armed_q;
    satf_d   = satf_q;
    vld_p0_d = '0;
    rec_p0_d = rec_p0_q;
    rej_any  = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      pat = {prev_q[c], sa_q[c], sb[c]};
      ev  = 1'b0;
      ph2 = 1'b0;
      gl  = 1'b0;
      rej = 1'b0;
      case (pat)
        3'b010:  begin ev = 1'b1; gl = 1'b1; end
        3'b011:  begin ev = 1'b1; end
        3'b001:  begin ev = 1'b1; ph2 = 1'b1; end
        3'b101:  begin ev = 1'b1; ph2 = 1'b1; gl = 1'b1; end
        default: ;
      endcase
`ifdef TMIV_CNT_MC_GLITCH_REJECT_EN
      if (gl) begin
        ev  = 1'b0;
        rej = 1'b1;
      end
`else
      rej = 1'b0;
`endif
      sum = sat_add(acc_q[c], ph2 ? 2'd2 : 2'd1);
      if (!en) begin
        acc_d[c]   = '0;
        armed_d[c] = 1'b0;
        satf_d[c]  = 1'b0;
      end else if (ev) begin
        vld_p0_d[c] = armed_q[c];
        rec_p0_d[c] = {gl, sum[CNT_W] | satf_q[c], 3'(c), sum[CNT_W-1:0]};
        acc_d[c]    = ph2 ? '0 : CNT_W'(1);
        armed_d[c]  = 1'b1;
        satf_d[c]   = 1'b0;
      end else begin
        sum       = sat_add(acc_q[c], 2'd2);
        acc_d[c]  = sum[CNT_W-1:0];
        satf_d[c] = satf_q[c] | sum[CNT_W];
        rej_any   = rej_any | rej;
      end
    end
  end

  // Stage p1: round-robin grant from the pending registers into the FIFO.
  always_comb begin
    int idx;
    idx     = 0;
    used    = wp_q - rp_q;
    full    = (used == (FIFO_AW+1)'(DEPTH));
    gnt     = '0;
    wr_en   = 1'b0;
    wr_data = prec_p1_q[0];
    ptr_d   = ptr_q;
    for (int k = 0; k < NCH; k++) begin
      idx = (int'(ptr_q) + k) % NCH;
      if (!wr_en && !full && pvld_p1_q[idx]) begin
        gnt[idx] = 1'b1;
        wr_en    = 1'b1;
        wr_data  = prec_p1_q[idx];
        ptr_d    = PW'((idx + 1) % NCH);
      end
    end
  end

  always_comb begin
    pvld_p1_d = pvld_p1_q & ~gnt;
    prec_p1_d = prec_p1_q;
    ndrop     = '0;
    for (int c = 0; c < NCH; c++) begin
      if (vld_p0_q[c]) begin
        if (!pvld_p1_q[c] || gnt[c]) begin
          pvld_p1_d[c] = 1'b1;
          prec_p1_d[c] = rec_p0_q[c];
        end else begin
          ndrop = ndrop + 4'd1;
        end
      end
    end
    drop_cnt_d = sat_drop(drop_cnt_q, ndrop);
    err_d      = (ndrop != 4'd0) | rej_any;
    rd_en      = out_valid & out_ready;
    wp_d       = wp_q + (FIFO_AW+1)'(wr_en);
    rp_d       = rp_q + (FIFO_AW+1)'(rd_en);
  end

  always_ff @(posedge hsclkp or negedge _rst) begin
    if (!_rst) begin
      syn_p_q    <= '0;
      sa_q       <= '0;
      prev_q     <= '0;
      acc_q      <= '0;
      armed_q    <= '0;
      satf_q     <= '0;
      vld_p0_q   <= '0;
      pvld_p1_q  <= '0;
      prec_p1_q  <= '0;
      ptr_q      <= '0;
      wp_q       <= '0;
      rp_q       <= '0;
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      syn_p_q    <= syn_p_d;
      sa_q       <= sa_d;
      prev_q     <= prev_d;
      acc_q      <= acc_d;
      armed_q    <= armed_d;
      satf_q     <= satf_d;
      vld_p0_q   <= vld_p0_d;
      pvld_p1_q  <= pvld_p1_d;
      prec_p1_q  <= prec_p1_d;
      ptr_q      <= ptr_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge hsclkp) begin
    rec_p0_q <= rec_p0_d;
  end

  // Stage p2: FIFO storage; head is presented show-ahead.
  always_ff @(posedge hsclkp) begin
    if (wr_en) mem_q[wp_q[FIFO_AW-1:0]] <= wr_data;
  end

  assign out_valid = (wp_q != rp_q);
  assign out_data  = out_valid ? mem_q[rp_q[FIFO_AW-1:0]] : '0;
  assign drop_cnt  = drop_cnt_q;
  assign err       = err_q;

endmodule
